// File: rtl/squash_ctrl_pkg.sv
// squash_ctrl_pkg: register map, CTRL/STATUS bit positions and FSM states for squash_ctrl
package squash_ctrl_pkg;
  localparam logic [3:0] OFS_CTRL    = 4'h0;
  localparam logic [3:0] OFS_STATUS  = 4'h4;
  localparam logic [3:0] OFS_FRAMES  = 4'h8;
  localparam logic [3:0] OFS_RST_LEN = 4'hC;
  localparam int CTRL_RUN        = 0;
  localparam int CTRL_PAUSE      = 1;
  localparam int CTRL_SW_SEL     = 2;
  localparam int CTRL_SW_UP      = 3;
  localparam int CTRL_SW_DOWN    = 4;
  localparam int CTRL_OE         = 5;
  localparam int CTRL_START      = 8;
  localparam int CTRL_IRQ_EN     = 9;
  localparam int STATUS_IRQ_PEND = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2, PAUSED = 2'd3} squash_state_t;
endpackage

// File: rtl/squash_btn_sync.sv
// squash_btn_sync: N-bit two-flop synchronizer for asynchronous pad inputs
module squash_btn_sync #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] m;
  always_ff @(posedge clk) begin
    if (!rst_n) {q, m} <= '0;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/squash_ctrl.sv
// squash_ctrl: Wishbone sequencer and button arbiter for solo_squash; `define SQUASH_CTRL_IRQ_EN enables the frame interrupt
module squash_ctrl
  import squash_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          RST_LEN_DEFAULT = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        pad_up_i,
  input  logic        pad_down_i,
  input  logic        game_vsync_i,
  output logic        game_rst_n_o,
  output logic        game_en_o,
  output logic        game_up_o,
  output logic        game_down_o,
  output logic        io_oe_o,
  output logic        irq_o
);
  logic [5:0] ctrl;
  logic [7:0] rst_len, hold_cnt;
  logic [31:0] frames, rdata;
  logic [3:0] ofs;
  logic [1:0] pad_s;
  logic irq_en, irq_pend, start_q, vs_q;
  logic hit, acc, wr, wr_ctrl, wr_status, wr_len, vs_edge, hold_done, btn_up, btn_down, unused;
  squash_state_t state;
  squash_btn_sync #(.N(2)) u_sync (
    .clk(wb_clk_i),
    .rst_n(wb_rst_n),
    .d({pad_up_i, pad_down_i}),
    .q(pad_s)
  );
  assign hit = wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign ofs = {wbs_adr_i[3:2], 2'b00};
  assign acc = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  // writes land in the ack cycle, so they become visible the cycle after ack
  assign wr = wbs_stb_i & wbs_cyc_i & wbs_we_i & wbs_ack_o & hit;
  assign wr_ctrl = wr && ofs == OFS_CTRL;
  assign wr_status = wr && ofs == OFS_STATUS;
  assign wr_len = wr && ofs == OFS_RST_LEN;
  assign vs_edge = game_vsync_i & ~vs_q;
  assign hold_done = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, rst_len};
  assign btn_up = ctrl[CTRL_SW_SEL] ? ctrl[CTRL_SW_UP] : pad_s[1];
  assign btn_down = ctrl[CTRL_SW_SEL] ? ctrl[CTRL_SW_DOWN] : pad_s[0];
  assign io_oe_o = ctrl[CTRL_OE];
  assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:10], wbs_dat_i[9], wbs_dat_i[7:6], wbs_adr_i[1:0]};
  always_comb begin
    rdata = !hit ? 32'd0 :
            ofs == OFS_CTRL ? {22'd0, irq_en, 3'd0, ctrl} :
            ofs == OFS_STATUS ? {29'd0, irq_pend, state} :
            ofs == OFS_FRAMES ? frames : {24'd0, rst_len};
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl <= '0;
      rst_len <= 8'(RST_LEN_DEFAULT);
      start_q <= 1'b0;
      vs_q <= 1'b0;
      frames <= '0;
      hold_cnt <= '0;
      state <= IDLE;
      game_rst_n_o <= 1'b0;
      game_en_o <= 1'b0;
      game_up_o <= 1'b0;
      game_down_o <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= acc ? rdata : '0;
      vs_q <= game_vsync_i;
      start_q <= wr_ctrl & wbs_sel_i[1] & wbs_dat_i[CTRL_START];
      if (wr_ctrl && wbs_sel_i[0]) ctrl <= wbs_dat_i[5:0];
      if (wr_len && wbs_sel_i[0]) rst_len <= wbs_dat_i[7:0];
      // START acts one cycle after the CTRL write, so a RUN=0 in the same write already wins
      state <= !ctrl[CTRL_RUN] ? IDLE :
               start_q ? HOLD :
               state == HOLD && hold_done ? RUN :
               state == RUN && ctrl[CTRL_PAUSE] ? PAUSED :
               state == PAUSED && !ctrl[CTRL_PAUSE] ? RUN : state;
      hold_cnt <= (state == HOLD && !start_q) ? hold_cnt + 8'd1 : 8'd0;
      if (start_q && ctrl[CTRL_RUN]) frames <= '0;
      else if (vs_edge && state == RUN) frames <= frames + 32'd1;
      game_rst_n_o <= state == RUN || state == PAUSED;
      game_en_o <= state == RUN;
      game_up_o <= btn_up & ~btn_down;
      game_down_o <= btn_down & ~btn_up;
    end
  end
`ifdef SQUASH_CTRL_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      irq_en <= 1'b0;
      irq_pend <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_ctrl && wbs_sel_i[1]) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      irq_pend <= (vs_edge && state == RUN) | (irq_pend & ~(wr_status & wbs_sel_i[0] & wbs_dat_i[STATUS_IRQ_PEND]));
      irq_o <= irq_pend & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq_pend = 1'b0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_squash_ctrl.sv
// tb_squash_ctrl: self-checking bench for squash_ctrl (register vectors, directed sequences, random model)
module tb_squash_ctrl;
  localparam logic [31:0] A_CTRL = 32'h3000_0000, A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_FRAMES = 32'h3000_0008, A_LEN = 32'h3000_000C;
  logic clk = 0, rst_n = 0;
  logic stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic ack, pad_up = 0, pad_down = 0, vsync = 0;
  logic g_rst_n, g_en, g_up, g_down, oe, irq;
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[20];
  always #5 clk = ~clk;
  squash_ctrl dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .pad_up_i(pad_up), .pad_down_i(pad_down), .game_vsync_i(vsync),
    .game_rst_n_o(g_rst_n), .game_en_o(g_en), .game_up_o(g_up), .game_down_o(g_down),
    .io_oe_o(oe), .irq_o(irq)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input bit vs_at_ack, output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; stb = 1; cyc = 1;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    if (!ack) chk("ack_timeout", 0, 1);
    r = rdat;
    if (vs_at_ack) vsync = 1;
    @(posedge clk); #1;
    stb = 0; cyc = 0; we = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(a, 1, d, 4'hF, 0, r);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    xfer(a, 0, 0, 4'hF, 0, r);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    @(negedge clk); vsync = 1;
    @(negedge clk); vsync = 0;
  endtask
  task automatic time_to_run(input int exp, input string name);
    int n = 0;
    while (!g_rst_n && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk(name, n, exp);
  endtask
  initial begin
    logic [31:0] d, v;
    int n, op;
    logic [5:0] ctrl_m;
    logic [7:0] len_m;
    logic [31:0] frames_m;
    logic pause_m, pu, pd, up_m, dn_m;
    vecs[0]  = '{A_CTRL,   0, 4'hF, 32'h0,         32'h0};
    vecs[1]  = '{A_STATUS, 0, 4'hF, 32'h0,         32'h0};
    vecs[2]  = '{A_FRAMES, 0, 4'hF, 32'h0,         32'h0};
    vecs[3]  = '{A_LEN,    0, 4'hF, 32'h0,         32'h8};
    vecs[4]  = '{A_LEN,    1, 4'hF, 32'hFFFF_FFA5, 32'h0};
    vecs[5]  = '{A_LEN,    0, 4'hF, 32'h0,         32'hA5};
    vecs[6]  = '{A_LEN,    1, 4'h2, 32'h0000_5600, 32'h0};
    vecs[7]  = '{A_LEN,    0, 4'hF, 32'h0,         32'hA5};
    vecs[8]  = '{A_CTRL,   1, 4'h1, 32'hFFFF_FFC2, 32'h0};
    vecs[9]  = '{A_CTRL,   0, 4'hF, 32'h0,         32'h2};
    vecs[10] = '{32'h3000_0010, 1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{32'h3000_0010, 0, 4'hF, 32'h0,    32'h0};
    vecs[12] = '{A_FRAMES, 1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{A_FRAMES, 0, 4'hF, 32'h0,         32'h0};
    vecs[14] = '{A_STATUS, 1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{A_STATUS, 0, 4'hF, 32'h0,         32'h0};
    vecs[16] = '{32'h4000_0000, 0, 4'hF, 32'h0,    32'h0};
    vecs[17] = '{A_CTRL,   1, 4'hF, 32'h0,         32'h0};
    vecs[18] = '{A_LEN,    1, 4'hF, 32'h8,         32'h0};
    vecs[19] = '{A_LEN,    0, 4'hF, 32'h0,         32'h8};
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_game_rst_n", g_rst_n, 0);
    chk("rst_en", g_en, 0);
    chk("rst_up_down", {g_up, g_down}, 0);
    chk("rst_oe", oe, 0);
    chk("rst_irq", irq, 0);
    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, 0, d);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), d, vecs[i].exp);
    end
    @(negedge clk); adr = A_CTRL; we = 0; stb = 1; cyc = 1; n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    stb = 0; cyc = 0;
    chk("ack_rate", n, 2);
    wr(A_CTRL, 32'h121);
    time_to_run(10, "hold_len8");
    chk("en_run", g_en, 1);
    chk("oe_on", oe, 1);
    rd(A_STATUS, d); chk("status_run", d, 2);
    repeat (5) pulse();
    wr(A_CTRL, 32'h23);
    cycles(2);
    chk("en_paused", g_en, 0);
    repeat (3) pulse();
    rd(A_FRAMES, d); chk("frames_paused", d, 5);
    rd(A_STATUS, d); chk("status_paused", d & 3, 3);
    wr(A_CTRL, 32'h21);
    cycles(2);
    pulse();
    rd(A_FRAMES, d); chk("frames_resumed", d, 6);
    @(negedge clk); pad_up = 1;
    cycles(2); chk("pad_up_2cyc", g_up, 0);
    cycles(1); chk("pad_up_3cyc", g_up, 1);
    @(negedge clk); pad_down = 1;
    cycles(3); chk("pad_both", {g_up, g_down}, 0);
    wr(A_CTRL, 32'h35);
    cycles(2); chk("sw_down", {g_up, g_down}, 1);
`ifdef SQUASH_CTRL_IRQ_EN
    wr(A_STATUS, 4);
    wr(A_CTRL, 32'h221);
    cycles(2); chk("irq_quiet", irq, 0);
    pulse();
    cycles(2); chk("irq_set", irq, 1);
    xfer(A_STATUS, 1, 4, 4'hF, 1, d);
    @(negedge clk); vsync = 0;
    cycles(2); chk("irq_set_wins", irq, 1);
    rd(A_STATUS, d); chk("status_pend", d, 6);
    wr(A_STATUS, 4);
    cycles(2); chk("irq_cleared", irq, 0);
    rd(A_STATUS, d); chk("status_cleared", d, 2);
`else
    wr(A_CTRL, 32'h221);
    pulse();
    cycles(2); chk("irq_tied", irq, 0);
    rd(A_CTRL, d); chk("irq_en_ro", d, 32'h21);
    rd(A_STATUS, d); chk("irq_pend_ro", d, 2);
`endif
    wr(A_LEN, 0);
    wr(A_CTRL, 32'h100);
    cycles(3);
    chk("start_norun_rst", g_rst_n, 0);
    rd(A_STATUS, d); chk("start_norun_idle", d, 0);
    wr(A_CTRL, 32'h101);
    time_to_run(3, "hold_len0");
    rd(A_STATUS, d); chk("status_len0", d & 3, 2);
    rd(A_FRAMES, d); chk("frames_cleared", d, 0);
    ctrl_m = 6'h01; pause_m = 0; frames_m = 0; pu = pad_up; pd = pad_down;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          pulse();
          if (!pause_m) frames_m++;
        end
        1: begin
          v = $urandom;
          ctrl_m = {v[5:1], 1'b1};
          wr(A_CTRL, {26'd0, ctrl_m});
          cycles(2);
          pause_m = ctrl_m[1];
          chk("rand_oe", oe, ctrl_m[5]);
        end
        2: begin
          len_m = 8'($urandom_range(0, 255));
          wr(A_LEN, {24'd0, len_m});
          rd(A_LEN, d); chk("rand_len", d, len_m);
        end
        3: begin
          rd(A_FRAMES, d); chk("rand_frames", d, frames_m);
        end
        4: begin
          rd(A_STATUS, d); chk("rand_state", d & 3, pause_m ? 3 : 2);
          chk("rand_en", g_en, !pause_m);
          chk("rand_irq", irq, 0);
        end
        default: begin
          @(negedge clk);
          pu = 1'($urandom); pd = 1'($urandom);
          pad_up = pu; pad_down = pd;
          cycles(4);
          up_m = ctrl_m[2] ? ctrl_m[3] : pu;
          dn_m = ctrl_m[2] ? ctrl_m[4] : pd;
          chk("rand_btn", {g_up, g_down}, {up_m && !dn_m, dn_m && !up_m});
        end
      endcase
    end
    @(negedge clk); adr = A_LEN; we = 0; stb = 1; cyc = 1;
    @(posedge clk); #1;
    chk("ack_before_rst", ack, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("ack_dropped", ack, 0);
    chk("rst_mid_game", g_rst_n, 0);
    stb = 0; cyc = 0;
    @(negedge clk); rst_n = 1;
    rd(A_LEN, d); chk("len_after_rst", d, 8);
    rd(A_CTRL, d); chk("ctrl_after_rst", d, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
